mips_multicycle_ctrl: RTL and testbench

- Moore-style control FSM for the 32-bit multicycle MIPS datapath.
- Sits directly upstream of the 32-bit ALU and drives its 3-bit function select (f[2:0]), the operand muxes and all datapath write enables.
- Consumes the ALU zero and overflow flags to resolve beq and to suppress write-back on signed overflow.
- Flags illegal instructions.

---
 rtl/mips_multicycle_ctrl_if.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       exc_ovf;
  logic       exc_ill;

  modport master (
    input  op, funct, zero, overflow,
    output alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
           memwrite, regdst, memtoreg, regwrite, exc_ovf, exc_ill
  );

  modport slave (
    output op, funct, zero, overflow,
    input  alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
           memwrite, regdst, memtoreg, regwrite, exc_ovf, exc_ill
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the 32-bit multicycle MIPS datapath.
// Datapath controls decode from state; exception pulses are registered.
module mips_multicycle_ctrl (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_ctrl_if.master        bus
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t     r_state;
  logic       r_ovf_q;
  logic       r_exc_ovf;
  logic       r_exc_ill;

  logic [2:0] w_funct_alu;
  logic       w_funct_ok;
  logic       w_addsub;

  // R-type funct to ALU select; unknown funct keeps the add default
  always_comb begin
    w_funct_alu = 3'b010;
    w_funct_ok  = 1'b1;
    case (bus.funct)
      FN_ADD:  w_funct_alu = 3'b010;
      FN_SUB:  w_funct_alu = 3'b110;
      FN_AND:  w_funct_alu = 3'b000;
      FN_OR:   w_funct_alu = 3'b001;
      FN_SLT:  w_funct_alu = 3'b111;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  // only add/sub can trap on signed overflow
  assign w_addsub = (bus.funct == FN_ADD) || (bus.funct == FN_SUB);

  // state sequencing, overflow capture and exception pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_ovf_q   <= 1'b0;
      r_exc_ovf <= 1'b0;
      r_exc_ill <= 1'b0;
    end else begin
      r_exc_ovf <= 1'b0;
      r_exc_ill <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ovf_q <= 1'b0;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JEX;
            default: begin
              r_state   <= S_FETCH;
              r_exc_ill <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  r_state <= (bus.op == OP_LW) ? S_MEMRD :
                              (bus.op == OP_SW) ? S_MEMWR : S_FETCH;
        S_MEMRD:   r_state <= S_MEMWB;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   r_state <= S_FETCH;
        S_EXECUTE: begin
          r_ovf_q <= bus.overflow & w_addsub;
          if (w_funct_ok) begin
            r_state <= S_ALUWB;
          end else begin
            r_state   <= S_FETCH;
            r_exc_ill <= 1'b1;
          end
        end
        S_ALUWB: begin
          r_exc_ovf <= r_ovf_q;
          r_state   <= S_FETCH;
        end
        S_BEQEX:   r_state <= S_FETCH;
        S_ADDIEX: begin
          r_ovf_q <= bus.overflow;
          r_state <= S_ADDIWB;
        end
        S_ADDIWB: begin
          r_exc_ovf <= r_ovf_q;
          r_state   <= S_FETCH;
        end
        S_JEX:     r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  logic [2:0] w_alucontrol;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic       w_pcen, w_iord, w_irwrite, w_memwrite;
  logic       w_regdst, w_memtoreg, w_regwrite;

  // Moore decode of datapath controls from the current state
  always_comb begin
    w_alucontrol = 3'b010;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_pcen       = 1'b0;
    w_iord       = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_regwrite   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = 1'b1;
        w_pcen    = 1'b1;
      end
      S_DECODE:  w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD:   w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca    = 1'b1;
        w_alucontrol = w_funct_alu;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = ~r_ovf_q;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = 3'b110;
        w_pcsrc      = 2'b01;
        w_pcen       = bus.zero;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB:  w_regwrite = ~r_ovf_q;
      S_JEX: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  // write enables are gated by reset so a pending write drops immediately
  assign bus.alucontrol = w_alucontrol;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.iord       = w_iord;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.pcen       = w_pcen     & reset;
  assign bus.irwrite    = w_irwrite  & reset;
  assign bus.memwrite   = w_memwrite & reset;
  assign bus.regwrite   = w_regwrite & reset;
  assign bus.exc_ovf    = r_exc_ovf;
  assign bus.exc_ill    = r_exc_ill;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle bench for the multicycle MIPS controller: each cycle's
// expected control word is queued with its stimulus and checked at negedge.
module tb_mips_multicycle_ctrl;
  logic clk;
  logic reset;

  mips_multicycle_ctrl_if ifc();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite, memwrite,
  //  regdst, memtoreg, regwrite, exc_ovf, exc_ill}
  logic [16:0] w_obs;
  assign w_obs = {ifc.alucontrol, ifc.alusrca, ifc.alusrcb, ifc.pcsrc,
                  ifc.pcen, ifc.iord, ifc.irwrite, ifc.memwrite,
                  ifc.regdst, ifc.memtoreg, ifc.regwrite,
                  ifc.exc_ovf, ifc.exc_ill};

  localparam logic [16:0] E_RST    = 17'b010_0_01_00_000000000;
  localparam logic [16:0] E_FETCH  = 17'b010_0_01_00_101000000;
  localparam logic [16:0] E_DECODE = 17'b010_0_11_00_000000000;
  localparam logic [16:0] E_MEMADR = 17'b010_1_10_00_000000000;
  localparam logic [16:0] E_MEMRD  = 17'b010_0_00_00_010000000;
  localparam logic [16:0] E_MEMWB  = 17'b010_0_00_00_000001100;
  localparam logic [16:0] E_MEMWR  = 17'b010_0_00_00_010100000;
  localparam logic [16:0] E_ADDIEX = 17'b010_1_10_00_000000000;
  localparam logic [16:0] E_JEX    = 17'b010_0_00_10_100000000;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_AND = 6'b100100, FN_BAD = 6'b000111;

  function automatic logic [16:0] e_exec(input logic [2:0] f);
    return {f, 1'b1, 2'b00, 2'b00, 9'b0};
  endfunction
  function automatic logic [16:0] e_aluwb(input logic ovf);
    return {3'b010, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, ~ovf, 2'b00};
  endfunction
  function automatic logic [16:0] e_beq(input logic z);
    return {3'b110, 1'b1, 2'b00, 2'b01, z, 8'b0};
  endfunction
  function automatic logic [16:0] e_addiwb(input logic ovf);
    return {3'b010, 1'b0, 2'b00, 2'b00, 6'b0, ~ovf, 2'b00};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ovf;
    logic [16:0] exp;
  } stim_t;

  stim_t       sq[$];
  logic [16:0] sb[$];
  int n_run  = 0;
  int n_fail = 0;

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic o, input logic [16:0] e);
    stim_t s;
    s.op = op; s.funct = fn; s.zero = z; s.ovf = o; s.exp = e;
    sq.push_back(s);
  endtask

  task automatic test_reset_lw();
    stim_t s;
    logic [16:0] e;
    int k;
    reset = 1'b0;
    ifc.op = OP_LW; ifc.funct = 6'b0; ifc.zero = 1'b0; ifc.overflow = 1'b0;
    #3;
    sb.push_back(E_RST);
    e = sb.pop_front(); n_run++;
    if (w_obs !== e) begin
      n_fail++; $display("FAIL reset_pre_edge got %05h expected %05h", w_obs, e);
    end
    @(posedge clk); #1;
    sb.push_back(E_RST);
    e = sb.pop_front(); n_run++;
    if (w_obs !== e) begin
      n_fail++; $display("FAIL reset_held got %05h expected %05h", w_obs, e);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    add(OP_LW, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_LW, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_LW, 6'b0, 1'b0, 1'b0, E_MEMADR);
    add(OP_LW, 6'b0, 1'b0, 1'b0, E_MEMRD);
    add(OP_LW, 6'b0, 1'b0, 1'b0, E_MEMWB);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL lw cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ovf();
    stim_t s;
    logic [16:0] e;
    int k;
    add(OP_R, FN_ADD, 1'b0, 1'b0, E_FETCH);
    add(OP_R, FN_ADD, 1'b0, 1'b0, E_DECODE);
    add(OP_R, FN_ADD, 1'b0, 1'b1, e_exec(3'b010));
    add(OP_R, FN_ADD, 1'b0, 1'b0, e_aluwb(1'b1));
    add(OP_R, FN_AND, 1'b0, 1'b0, E_FETCH | 17'd2);
    add(OP_R, FN_AND, 1'b0, 1'b0, E_DECODE);
    add(OP_R, FN_AND, 1'b0, 1'b1, e_exec(3'b000));
    add(OP_R, FN_AND, 1'b0, 1'b0, e_aluwb(1'b0));
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_ADDI, 6'b0, 1'b0, 1'b1, E_ADDIEX);
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, e_addiwb(1'b1));
    add(OP_J, 6'b0, 1'b0, 1'b0, E_FETCH | 17'd2);
    add(OP_J, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_J, 6'b0, 1'b0, 1'b0, E_JEX);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL alu_ovf cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    stim_t s;
    logic [16:0] e;
    int k;
    add(OP_BEQ, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_BEQ, 6'b0, 1'b1, 1'b0, E_DECODE);
    add(OP_BEQ, 6'b0, 1'b1, 1'b0, e_beq(1'b1));
    add(OP_BEQ, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_BEQ, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_BEQ, 6'b0, 1'b0, 1'b0, e_beq(1'b0));
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL beq cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    stim_t s;
    logic [16:0] e;
    int k;
    add(OP_BAD, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_BAD, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_R, FN_BAD, 1'b0, 1'b0, E_FETCH | 17'd1);
    add(OP_R, FN_BAD, 1'b0, 1'b0, E_DECODE);
    add(OP_R, FN_BAD, 1'b0, 1'b1, e_exec(3'b010));
    add(OP_J, 6'b0, 1'b0, 1'b0, E_FETCH | 17'd1);
    add(OP_J, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_J, 6'b0, 1'b0, 1'b0, E_JEX);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL illegal cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic [16:0] e;
    int k;
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_MEMADR);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_MEMWR);
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, E_ADDIEX);
    add(OP_ADDI, 6'b0, 1'b0, 1'b0, e_addiwb(1'b0));
    add(OP_J, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_J, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_J, 6'b0, 1'b0, 1'b0, E_JEX);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL b2b cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    logic [16:0] e;
    int k;
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_FETCH);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_MEMADR);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL rst_mid cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
    // now in MEMWR, between edges
    #1;
    sb.push_back(E_MEMWR);
    e = sb.pop_front(); n_run++;
    if (w_obs !== e) begin
      n_fail++; $display("FAIL rst_mid_memwr got %05h expected %05h", w_obs, e);
    end
    reset = 1'b0;
    #1;
    sb.push_back(E_RST);
    e = sb.pop_front(); n_run++;
    if (w_obs !== e) begin
      n_fail++; $display("FAIL rst_mid_drop got %05h expected %05h", w_obs, e);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    sb.push_back(E_FETCH);
    e = sb.pop_front(); n_run++;
    if (w_obs !== e) begin
      n_fail++; $display("FAIL rst_mid_release got %05h expected %05h", w_obs, e);
    end
    @(posedge clk); #1;
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_DECODE);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_MEMADR);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_MEMWR);
    add(OP_SW, 6'b0, 1'b0, 1'b0, E_FETCH);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      ifc.op = s.op; ifc.funct = s.funct; ifc.zero = s.zero; ifc.overflow = s.ovf;
      sb.push_back(s.exp);
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL rst_mid_after cycle %0d got %05h expected %05h", k, w_obs, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_lw();
    test_alu_ovf();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
